mmc_irq_counter: RTL

- Parametrised scanline/cycle IRQ counter for MMC3-family mappers, generalising the fixed 8-bit, 4-sample A12 counter used in current MMC3 variants.
- Adds configurable counter width, configurable A12 filter depth, a runtime-selectable Rev A / Rev B reload rule, and an M2-cycle counting mode with prescaler (Rambo-1 style).
- Adds a save-state load path.
- Instantiated inside a mapper module; drives that mapper's irq output.

---
 rtl/mmc_irq_counter_if.sv | 24 ++
 rtl/mmc_irq_counter.sv | 117 +++++++++++
 2 files changed

// File: rtl/mmc_irq_counter_if.sv
// Register-write, save-state load and save-state readback bundle between a
// mapper's register decode and its IRQ counter.
interface mmc_irq_counter_if #(
    parameter int CNT_W = 8
);
    logic             reg_we;
    logic [1:0]       reg_sel;
    logic [CNT_W-1:0] reg_dat;
    logic             ss_ld;
    logic [CNT_W-1:0] ss_ctr;
    logic [2:0]       ss_flags;
    logic [CNT_W-1:0] ctr;
    logic [2:0]       flags;

    modport master (
        output reg_we, reg_sel, reg_dat, ss_ld, ss_ctr, ss_flags,
        input  ctr, flags
    );

    modport slave (
        input  reg_we, reg_sel, reg_dat, ss_ld, ss_ctr, ss_flags,
        output ctr, flags
    );
endinterface

// File: rtl/mmc_irq_counter.sv
// MMC3-family scanline/cycle IRQ counter: filtered-A12 or M2-prescaled events,
// Rev A / Rev B reload rule, save-state load and readback.
module mmc_irq_counter #(
    parameter int CNT_W    = 8,
    parameter int FILT_LEN = 4,
    parameter int PRESC    = 4,
    parameter int PRESC_W  = 2
) (
    input  logic               m2,
    input  logic               map_rst,
    input  logic               ppu_a12,
    input  logic               mode_b,
    input  logic               cyc_mode,
    mmc_irq_counter_if.slave   bus,
    output logic               irq
);

    typedef enum logic [1:0] {
        SEL_LATCH  = 2'd0,
        SEL_RELOAD = 2'd1,
        SEL_ACK    = 2'd2,
        SEL_EN     = 2'd3
    } reg_sel_e;

    logic [CNT_W-1:0]    ctr_q, ctr_d;
    logic [CNT_W-1:0]    latch_q, latch_d;
    logic                en_q, en_d;
    logic                pend_q, pend_d;
    logic                reload_q, reload_d;
    logic [PRESC_W-1:0]  presc_q, presc_d;
    logic [FILT_LEN-1:0] filt_q, filt_d;

    logic             a12_evt;
    logic             cyc_evt;
    logic             evt;
    logic [CNT_W-1:0] nxt;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the
        // if/case below can leave one unassigned and infer a latch.
        ctr_d    = ctr_q;
        latch_d  = latch_q;
        en_d     = en_q;
        pend_d   = pend_q;
        reload_d = reload_q;

        filt_d  = (filt_q << 1) | FILT_LEN'(ppu_a12);
        a12_evt = ppu_a12 & (filt_q == '0);

        cyc_evt = cyc_mode & (presc_q == PRESC_W'(PRESC - 1));
        if (!cyc_mode || cyc_evt) presc_d = '0;
        else                      presc_d = presc_q + PRESC_W'(1);

        evt = cyc_mode ? cyc_evt : a12_evt;
        nxt = (reload_q || ctr_q == '0) ? latch_q : ctr_q - CNT_W'(1);

        if (evt) begin
            ctr_d    = nxt;
            reload_d = 1'b0;
            // Rev A only fires on a real count-down or an explicit reload.
            if (en_q && nxt == '0 && (mode_b || ctr_q != '0 || reload_q))
                pend_d = 1'b1;
        end

        // Writes land after the event so they win on every field they touch.
        if (bus.reg_we) begin
            unique case (reg_sel_e'(bus.reg_sel))
                SEL_LATCH:  latch_d = bus.reg_dat;
                SEL_RELOAD: begin
                    ctr_d    = '0;
                    reload_d = 1'b1;
                    if (cyc_mode) presc_d = '0;
                end
                SEL_ACK: begin
                    en_d   = 1'b0;
                    pend_d = 1'b0;
                end
                SEL_EN:     en_d = 1'b1;
            endcase
        end

        // Save-state restore overrides the counter and flags only; the latch,
        // filter and prescaler carry on as normal.
        if (bus.ss_ld) begin
            ctr_d                    = bus.ss_ctr;
            {en_d, pend_d, reload_d} = bus.ss_flags;
        end
    end

    always_ff @(negedge m2 or posedge map_rst) begin
        if (map_rst) begin
            ctr_q    <= '0;
            latch_q  <= '0;
            en_q     <= 1'b0;
            pend_q   <= 1'b0;
            reload_q <= 1'b0;
            presc_q  <= '0;
            // All ones so an A12 already high at reset release is not an edge.
            filt_q   <= '1;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values computed above, independent of statement order.
            ctr_q    <= ctr_d;
            latch_q  <= latch_d;
            en_q     <= en_d;
            pend_q   <= pend_d;
            reload_q <= reload_d;
            presc_q  <= presc_d;
            filt_q   <= filt_d;
        end
    end

    assign irq       = pend_q;
    assign bus.ctr   = ctr_q;
    assign bus.flags = {en_q, pend_q, reload_q};

endmodule
